seven_segment_scan_decoder: RTL and testbench
=============================================

Name: seven_segment_scan_decoder

Overview:
Reader for a time-multiplexed, active-low seven-segment display bus: samples segment and digit-anode lines, waits for each digit to be stable, and decodes segments back to BCD. Assembles one complete scan of NUM_DIGITS digits into a packed BCD word and signals it with a one-cycle frame_valid strobe. Sits downstream of the BCD-to-seven-segment driver and scan logic; used for loopback self-test and for capturing external display buses.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (anodes); legal 1..8
STABLE_CYCLES, 4, consecutive identical synchronized samples required before a digit is captured; legal 2..255
SYNC_STAGES, 2, flip-flop synchronizer depth on seg_n and an_n; legal 2..3

Ports:
clk  input  1  single clock; all state on rising edge
reset  input  1  asynchronous, active-high reset
seg_n  input  7  segments, active low; bit0=a ... bit6=g
an_n  input  NUM_DIGITS  digit enables, active low; bit i selects digit i
bcd_out  output  4*NUM_DIGITS  digit i at bits [4i+3:4i], registered
digit_err  output  NUM_DIGITS  bit i set if digit i's segment pattern was illegal, registered
frame_valid  output  1  one-cycle strobe: bcd_out/digit_err just updated

Behaviour:
- Reset (async assert, sync release): bcd_out=0, digit_err=0, frame_valid=0, synchronizers and shadow registers cleared, capture mask cleared, stability counter 0, FSM to IDLE.
- Inputs pass through SYNC_STAGES flops; all logic below uses synchronized values (s_seg, s_an).
- Digit select valid only when ~s_an is exactly one-hot; all-high or multi-low = no digit.
- Decode table (s_seg -> code): 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0011000->9. 1111111 (blank) -> 4'hF, err=0. Any other pattern -> 4'hE, err=1. Exact match only (no alternate 6/7/9 forms).
- Stability counter: resets to 0 when {s_seg,s_an} differs from previous cycle's value or no valid digit; otherwise increments, saturating.
- FSM: IDLE: no valid digit; -> TRACK when valid one-hot appears. TRACK: counting; -> IDLE if select becomes invalid; stays TRACK (counter restarts) if value changes to another valid value; -> CAPTURED on the cycle count reaches STABLE_CYCLES consecutive identical samples, writing code/err into shadow slot i and setting mask bit i. CAPTURED: no further capture while value unchanged; any change -> TRACK (valid) or IDLE (invalid).
- A digit is captured at most once per stable period. Re-capture of a digit already in mask before frame completes overwrites its shadow slot.
- Frame completion: the capture that makes mask all ones also copies all shadow slots (including the digit captured that edge) to bcd_out/digit_err on the next edge with frame_valid=1 for exactly that cycle; mask cleared on the same edge. Capture and frame completion in the same cycle are both honoured; the new frame's mask starts empty.
- Latency: input held from edge 0 -> capture at edge SYNC_STAGES+STABLE_CYCLES-1; frame_valid one cycle after the last digit's capture.
- bcd_out/digit_err hold between frames; never partially updated.
- Reset mid-frame discards partial frame; first frame after reset requires all digits captured anew.
- NUM_DIGITS=1: every capture completes a frame.

Test Plan:
- Loopback scan: drive digits 0..3 = 2,0,2,5 (an_n 1110,1101,1011,0111), 8 cycles each -> one frame_valid pulse, bcd_out=16'h5202, digit_err=0.
- Glitch rejection: digit 0 shows 1111001 for 3 cycles then 0110000 for 8 -> digit 0 captured as 3, never 1; exactly one frame_valid after full scan.
- Illegal and blank: digit 1=0010000, digit 2=1111111, others 8 -> bcd_out=16'h8FE8, digit_err=4'b0010.
- Multi-hot/ghosting: an_n=1100 and 1111 held 20 cycles -> no capture, no frame_valid, outputs unchanged.
- Latency check: single stable digit from edge 0 -> shadow write at edge 5; with last missing digit, frame_valid high at edge 6 only.
- Reset mid-frame: capture digits 0,1, assert reset, then scan 9,9,9,9 -> bcd_out 0 during reset, then 16'h9999 with one frame_valid; no frame from pre-reset digits.

Source files
------------

// File: rtl/seven_segment_scan_decoder_if.sv
// Bundles the multiplexed seven-segment bus (seg_n/an_n) with the decoded
// frame outputs of the scan decoder.
interface seven_segment_scan_decoder_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              seg_n;
    logic [NUM_DIGITS-1:0]   an_n;
    logic [4*NUM_DIGITS-1:0] bcd_out;
    logic [NUM_DIGITS-1:0]   digit_err;
    logic                    frame_valid;

    modport master (
        output seg_n,
        output an_n,
        input  bcd_out,
        input  digit_err,
        input  frame_valid
    );

    modport slave (
        input  seg_n,
        input  an_n,
        output bcd_out,
        output digit_err,
        output frame_valid
    );
endinterface

// File: rtl/seven_segment_scan_decoder.sv
// Reads a multiplexed active-low seven-segment bus, waits for each digit to be
// stable, decodes it back to BCD and publishes one complete scan per frame.
module seven_segment_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    seven_segment_scan_decoder_if.slave   bus
);
    localparam int W = 7 + NUM_DIGITS;
    // cnt_q counts repeats after the first sample of a run, so a run of
    // STABLE_CYCLES identical samples is complete when cnt_q hits STABLE_CYCLES-2
    // on a cycle whose sample still matches.
    localparam logic [7:0] CAP_CNT = 8'(STABLE_CYCLES - 2);

    typedef enum logic [1:0] {IDLE, TRACK, CAPTURED} state_t;

    logic [SYNC_STAGES*W-1:0] sync_q, sync_d;
    logic [W-1:0]             prev_q, prev_d;
    logic [7:0]               cnt_q, cnt_d;
    state_t                   state_q, state_d;
    logic [NUM_DIGITS-1:0]    mask_q, mask_d;
    logic                     pending_q, pending_d;
    logic [4*NUM_DIGITS-1:0]  shadow_code_q, shadow_code_d;
    logic [NUM_DIGITS-1:0]    shadow_err_q, shadow_err_d;
    logic [4*NUM_DIGITS-1:0]  bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]    err_q, err_d;
    logic                     fv_q, fv_d;

    logic [6:0]               s_seg;
    logic [NUM_DIGITS-1:0]    s_an;
    logic [NUM_DIGITS-1:0]    sel;
    logic                     valid;
    logic                     same;
    logic                     capture;
    logic [3:0]               code;
    logic                     code_err;
    logic [NUM_DIGITS-1:0]    mask_cap;

    assign sync_d = {sync_q[(SYNC_STAGES-1)*W-1:0], bus.seg_n, bus.an_n};
    assign {s_seg, s_an} = sync_q[SYNC_STAGES*W-1 -: W];
    assign prev_d = {s_seg, s_an};

    assign sel   = ~s_an;
    assign valid = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
    assign same  = ({s_seg, s_an} == prev_q);

    always_comb begin
        code     = 4'hE;
        code_err = 1'b1;
        case (s_seg)
            7'b1000000: begin code = 4'd0; code_err = 1'b0; end
            7'b1111001: begin code = 4'd1; code_err = 1'b0; end
            7'b0100100: begin code = 4'd2; code_err = 1'b0; end
            7'b0110000: begin code = 4'd3; code_err = 1'b0; end
            7'b0011001: begin code = 4'd4; code_err = 1'b0; end
            7'b0010010: begin code = 4'd5; code_err = 1'b0; end
            7'b0000010: begin code = 4'd6; code_err = 1'b0; end
            7'b1111000: begin code = 4'd7; code_err = 1'b0; end
            7'b0000000: begin code = 4'd8; code_err = 1'b0; end
            7'b0011000: begin code = 4'd9; code_err = 1'b0; end
            7'b1111111: begin code = 4'hF; code_err = 1'b0; end
            default:    begin code = 4'hE; code_err = 1'b1; end
        endcase
    end

    always_comb begin
        cnt_d = 8'd0;
        if (valid && same) begin
            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (valid) state_d = TRACK;
            end
            TRACK: begin
                if (!valid)       state_d = IDLE;
                else if (capture) state_d = CAPTURED;
            end
            CAPTURED: begin
                if (!valid)     state_d = IDLE;
                else if (!same) state_d = TRACK;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        capture = 1'b0;
        if (state_q == TRACK && valid && same && cnt_q == CAP_CNT) begin
            capture = 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
            assign shadow_code_d[4*gi +: 4] = (capture && sel[gi]) ? code : shadow_code_q[4*gi +: 4];
            assign shadow_err_d[gi]         = (capture && sel[gi]) ? code_err : shadow_err_q[gi];
        end
    endgenerate

    // The capture completing a frame clears the mask right away; the copy to
    // the outputs follows one edge later from the shadow registers.
    always_comb begin
        mask_cap  = mask_q | sel;
        mask_d    = mask_q;
        pending_d = 1'b0;
        if (capture) begin
            if (mask_cap == '1) begin
                mask_d    = '0;
                pending_d = 1'b1;
            end else begin
                mask_d = mask_cap;
            end
        end
    end

    always_comb begin
        bcd_d = bcd_q;
        err_d = err_q;
        fv_d  = pending_q;
        if (pending_q) begin
            bcd_d = shadow_code_q;
            err_d = shadow_err_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q        <= '0;
            prev_q        <= '0;
            cnt_q         <= 8'd0;
            mask_q        <= '0;
            pending_q     <= 1'b0;
            shadow_code_q <= '0;
            shadow_err_q  <= '0;
            bcd_q         <= '0;
            err_q         <= '0;
            fv_q          <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            prev_q        <= prev_d;
            cnt_q         <= cnt_d;
            mask_q        <= mask_d;
            pending_q     <= pending_d;
            shadow_code_q <= shadow_code_d;
            shadow_err_q  <= shadow_err_d;
            bcd_q         <= bcd_d;
            err_q         <= err_d;
            fv_q          <= fv_d;
        end
    end

    assign bus.bcd_out     = bcd_q;
    assign bus.digit_err   = err_q;
    assign bus.frame_valid = fv_q;
endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Directed bench for seven_segment_scan_decoder: scans, glitches, illegal
// patterns, ghosting, capture latency and reset mid-frame.
module tb_seven_segment_scan_decoder;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   fv_cnt = 0;
    int   fv_base;
    logic [6:0] seg_tab [10];
    logic [N-1:0] an_tab [N];

    seven_segment_scan_decoder_if #(.NUM_DIGITS(N)) bus ();

    seven_segment_scan_decoder #(
        .NUM_DIGITS(N),
        .STABLE_CYCLES(4),
        .SYNC_STAGES(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.frame_valid === 1'b1) fv_cnt = fv_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called at a negedge; drives the bus and returns n negedges later.
    task automatic hold(input logic [6:0] seg, input logic [N-1:0] an, input int n);
        bus.seg_n = seg;
        bus.an_n  = an;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [6:0] s0, input logic [6:0] s1,
                        input logic [6:0] s2, input logic [6:0] s3);
        hold(s0, an_tab[0], 8);
        hold(s1, an_tab[1], 8);
        hold(s2, an_tab[2], 8);
        hold(s3, an_tab[3], 8);
        hold(7'h7F, 4'b1111, 4);
    endtask

    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
        seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
        seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
        seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0011000;
        an_tab[0] = 4'b1110; an_tab[1] = 4'b1101;
        an_tab[2] = 4'b1011; an_tab[3] = 4'b0111;

        reset = 1'b1;
        bus.seg_n = 7'h7F;
        bus.an_n  = 4'b1111;
        repeat (3) @(negedge clk);
        check("rst_bcd", bus.bcd_out, 16'h0000);
        check("rst_err", bus.digit_err, 4'b0000);
        check("rst_fv", bus.frame_valid, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Loopback scan 2,0,2,5
        fv_base = fv_cnt;
        scan(seg_tab[2], seg_tab[0], seg_tab[2], seg_tab[5]);
        check("loop_fv_count", fv_cnt - fv_base, 1);
        check("loop_bcd", bus.bcd_out, 16'h5202);
        check("loop_err", bus.digit_err, 4'b0000);

        // Glitch: digit 0 shows "1" for 3 cycles before settling on 3
        fv_base = fv_cnt;
        hold(seg_tab[1], an_tab[0], 3);
        scan(seg_tab[3], seg_tab[7], seg_tab[8], seg_tab[9]);
        check("glitch_fv_count", fv_cnt - fv_base, 1);
        check("glitch_bcd", bus.bcd_out, 16'h9873);
        check("glitch_err", bus.digit_err, 4'b0000);

        // Illegal and blank patterns
        fv_base = fv_cnt;
        scan(seg_tab[8], 7'b0010000, 7'b1111111, seg_tab[8]);
        check("illegal_fv_count", fv_cnt - fv_base, 1);
        check("illegal_bcd", bus.bcd_out, 16'h8FE8);
        check("illegal_err", bus.digit_err, 4'b0010);

        // Multi-hot and all-off anodes must never capture
        fv_base = fv_cnt;
        hold(seg_tab[8], 4'b1100, 20);
        hold(seg_tab[8], 4'b1111, 20);
        check("ghost_fv_count", fv_cnt - fv_base, 0);
        check("ghost_bcd", bus.bcd_out, 16'h8FE8);
        check("ghost_err", bus.digit_err, 4'b0010);

        // Latency: last digit presented just before edge 0, frame_valid at edge 6 only
        hold(seg_tab[1], an_tab[0], 8);
        hold(seg_tab[2], an_tab[1], 8);
        hold(seg_tab[3], an_tab[2], 8);
        bus.seg_n = seg_tab[4];
        bus.an_n  = an_tab[3];
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check($sformatf("lat_fv_edge%0d", k), bus.frame_valid, (k == 6) ? 1 : 0);
        end
        check("lat_bcd", bus.bcd_out, 16'h4321);
        hold(7'h7F, 4'b1111, 4);

        // Reset mid-frame discards captured digits 0 and 1
        hold(seg_tab[7], an_tab[0], 8);
        hold(seg_tab[7], an_tab[1], 8);
        reset = 1'b1;
        hold(7'h7F, 4'b1111, 1);
        check("midrst_bcd", bus.bcd_out, 16'h0000);
        check("midrst_fv", bus.frame_valid, 1'b0);
        hold(7'h7F, 4'b1111, 2);
        reset = 1'b0;
        @(negedge clk);
        fv_base = fv_cnt;
        hold(seg_tab[9], an_tab[2], 8);
        hold(seg_tab[9], an_tab[3], 8);
        hold(7'h7F, 4'b1111, 4);
        check("midrst_partial_fv", fv_cnt - fv_base, 0);
        check("midrst_partial_bcd", bus.bcd_out, 16'h0000);
        scan(seg_tab[9], seg_tab[9], seg_tab[9], seg_tab[9]);
        check("midrst_fv_count", fv_cnt - fv_base, 1);
        check("midrst_bcd_final", bus.bcd_out, 16'h9999);
        check("midrst_err_final", bus.digit_err, 4'b0000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
